// File: rtl/rggen_response_stage.sv
// Response stage behind the register block's one-hot read-data mux.
// It strobes the selected entry, waits for that entry's ready, and holds the
// registered result on a valid/ready handshake.

module rggen_mux #(
  parameter int WIDTH   = 1,
  parameter int ENTRIES = 2
) (
  input  logic [ENTRIES-1:0]       i_select,
  input  logic [WIDTH*ENTRIES-1:0] i_data,
  output logic [WIDTH-1:0]         o_data
);

  // AND-OR mux: a single-hot select yields exactly that entry's slice.
  always_comb begin
    o_data = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      o_data = o_data | (i_data[i*WIDTH+:WIDTH] & {WIDTH{i_select[i]}});
    end
  end

endmodule

module rggen_response_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ENTRIES    = 2,
  parameter int TIMEOUT    = 0
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_request_valid,
  output logic                          o_request_ready,
  input  logic                          i_request_write,
  input  logic [ENTRIES-1:0]            i_select,
  output logic                          o_access_active,
  input  logic [ENTRIES-1:0]            i_ready,
  input  logic [2*ENTRIES-1:0]          i_status,
  input  logic [DATA_WIDTH*ENTRIES-1:0] i_data,
  output logic                          o_response_valid,
  input  logic                          i_response_ready,
  output logic [1:0]                    o_status,
  output logic [DATA_WIDTH-1:0]         o_read_data
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [1:0] STATUS_OKAY   = 2'b00;
  localparam logic [1:0] STATUS_SLVERR = 2'b10;
  localparam logic [1:0] STATUS_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e                  state;
  logic [CNT_W-1:0]        count;
  logic                    write_q;
  logic                    select_onehot;
  logic                    hit;
  logic                    timeout_hit;
  logic [1:0]              mux_status;
  logic [DATA_WIDTH-1:0]   mux_data;

  rggen_mux #(
    .WIDTH   (2),
    .ENTRIES (ENTRIES)
  ) u_status_mux (
    .i_select (i_select),
    .i_data   (i_status),
    .o_data   (mux_status)
  );

  rggen_mux #(
    .WIDTH   (DATA_WIDTH),
    .ENTRIES (ENTRIES)
  ) u_data_mux (
    .i_select (i_select),
    .i_data   (i_data),
    .o_data   (mux_data)
  );

  // A zero or multi-hot select is a decode error and never reaches the entries.
  assign select_onehot = (i_select != '0) &&
                         ((i_select & (i_select - 1'b1)) == '0);
  assign hit           = |(i_select & i_ready);
  assign timeout_hit   = (TIMEOUT > 0) && (count == TIMEOUT_LAST);

  assign o_request_ready = (state == IDLE);
  assign o_access_active = (state == WAIT);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state            <= IDLE;
      count            <= '0;
      write_q          <= 1'b0;
      o_response_valid <= 1'b0;
      o_status         <= STATUS_OKAY;
      o_read_data      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_request_valid) begin
            write_q <= i_request_write;
            if (select_onehot) begin
              state <= WAIT;
              count <= '0;
            end else begin
              state            <= RESP;
              o_response_valid <= 1'b1;
              o_status         <= STATUS_DECERR;
              o_read_data      <= '0;
            end
          end
        end
        WAIT: begin
          // A hit on the last allowed cycle still beats the timeout.
          if (hit) begin
            state            <= RESP;
            o_response_valid <= 1'b1;
            o_status         <= mux_status;
            o_read_data      <= write_q ? '0 : mux_data;
          end else if (timeout_hit) begin
            state            <= RESP;
            o_response_valid <= 1'b1;
            o_status         <= STATUS_SLVERR;
            o_read_data      <= '0;
          end else if (TIMEOUT > 0) begin
            count <= count + 1'b1;
          end
        end
        RESP: begin
          if (i_response_ready) begin
            state            <= IDLE;
            o_response_valid <= 1'b0;
          end
        end
        default: begin
          state            <= IDLE;
          o_response_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rggen_response_stage.sv
// Directed bench for rggen_response_stage (4 entries, timeout of 8 cycles).

module tb_rggen_response_stage;

  logic         clk;
  logic         rst;
  logic         request_valid;
  logic         request_ready;
  logic         request_write;
  logic [3:0]   select;
  logic         access_active;
  logic [3:0]   ready;
  logic [7:0]   status;
  logic [127:0] data;
  logic         response_valid;
  logic         response_ready;
  logic [1:0]   resp_status;
  logic [31:0]  read_data;

  int checks;
  int errors;
  int active_cycles;

  rggen_response_stage #(
    .DATA_WIDTH (32),
    .ENTRIES    (4),
    .TIMEOUT    (8)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_request_valid  (request_valid),
    .o_request_ready  (request_ready),
    .i_request_write  (request_write),
    .i_select         (select),
    .o_access_active  (access_active),
    .i_ready          (ready),
    .i_status         (status),
    .i_data           (data),
    .o_response_valid (response_valid),
    .i_response_ready (response_ready),
    .o_status         (resp_status),
    .o_read_data      (read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, {31'd0, response_valid}, 32'd0);
    check({tag, "_status"}, {30'd0, resp_status}, 32'd0);
    check({tag, "_data"}, read_data, 32'd0);
    check({tag, "_active"}, {31'd0, access_active}, 32'd0);
    check({tag, "_req_ready"}, {31'd0, request_ready}, 32'd1);
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst            = 1'b1;
    request_valid  = 1'b0;
    request_write  = 1'b0;
    select         = 4'b0000;
    ready          = 4'b0000;
    status         = 8'h00;
    data           = '0;
    response_ready = 1'b0;

    #12;
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Read of entry 2, ready after 3 WAIT cycles; unselected entry 1 is ready early.
    ready[1]         = 1'b1;
    status[3:2]      = 2'b11;
    data[32 +: 32]   = 32'hFFFF0000;
    data[64 +: 32]   = 32'hDEADBEEF;
    status[5:4]      = 2'b00;
    select           = 4'b0100;
    request_write    = 1'b0;
    request_valid    = 1'b1;
    check("rd_req_ready", {31'd0, request_ready}, 32'd1);
    tick();
    request_valid = 1'b0;
    active_cycles = 0;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) ready[2] = 1'b1;
      if (access_active) active_cycles++;
      tick();
    end
    check("rd_active_cycles", active_cycles, 32'd3);
    check("rd_valid", {31'd0, response_valid}, 32'd1);
    check("rd_active_after", {31'd0, access_active}, 32'd0);
    check("rd_status", {30'd0, resp_status}, 32'd0);
    check("rd_data", read_data, 32'hDEADBEEF);
    response_ready = 1'b1;
    ready          = 4'b0000;
    tick();
    response_ready = 1'b0;
    check("rd_valid_drop", {31'd0, response_valid}, 32'd0);

    // Zero select: immediate decode error, no WAIT.
    select        = 4'b0000;
    request_valid = 1'b1;
    tick();
    request_valid = 1'b0;
    check("dec0_active", {31'd0, access_active}, 32'd0);
    check("dec0_valid", {31'd0, response_valid}, 32'd1);
    check("dec0_status", {30'd0, resp_status}, 32'd3);
    check("dec0_data", read_data, 32'd0);
    response_ready = 1'b1;
    tick();
    response_ready = 1'b0;

    // Write to entry 0, SLVERR from the entry, data forced to zero.
    select         = 4'b0001;
    status[1:0]    = 2'b10;
    data[0 +: 32]  = 32'h12345678;
    request_write  = 1'b1;
    request_valid  = 1'b1;
    tick();
    request_valid  = 1'b0;
    request_write  = 1'b0;
    check("wr_active", {31'd0, access_active}, 32'd1);
    ready[0] = 1'b1;
    tick();
    check("wr_valid", {31'd0, response_valid}, 32'd1);
    check("wr_status", {30'd0, resp_status}, 32'd2);
    check("wr_data", read_data, 32'd0);
    response_ready = 1'b1;
    ready          = 4'b0000;
    tick();
    response_ready = 1'b0;

    // Multi-hot select: decode error.
    select        = 4'b0110;
    request_valid = 1'b1;
    tick();
    request_valid = 1'b0;
    check("dec2_active", {31'd0, access_active}, 32'd0);
    check("dec2_valid", {31'd0, response_valid}, 32'd1);
    check("dec2_status", {30'd0, resp_status}, 32'd3);
    check("dec2_data", read_data, 32'd0);
    response_ready = 1'b1;
    tick();
    response_ready = 1'b0;

    // Timeout: entry 3 never ready, exactly 8 WAIT cycles then SLVERR.
    select        = 4'b1000;
    data[96 +: 32] = 32'hCAFEF00D;
    status[7:6]   = 2'b00;
    request_valid = 1'b1;
    tick();
    request_valid = 1'b0;
    active_cycles = 0;
    for (int k = 0; k < 8; k++) begin
      if (access_active) active_cycles++;
      tick();
    end
    check("to_wait_cycles", active_cycles, 32'd8);
    check("to_valid", {31'd0, response_valid}, 32'd1);
    check("to_status", {30'd0, resp_status}, 32'd2);
    check("to_data", read_data, 32'd0);
    response_ready = 1'b1;
    tick();
    response_ready = 1'b0;

    // Ready on the 8th WAIT cycle wins over the timeout.
    request_valid = 1'b1;
    tick();
    request_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k == 7) ready[3] = 1'b1;
      tick();
    end
    ready[3] = 1'b0;
    check("tohit_valid", {31'd0, response_valid}, 32'd1);
    check("tohit_status", {30'd0, resp_status}, 32'd0);
    check("tohit_data", read_data, 32'hCAFEF00D);

    // Back-pressure for 4 cycles with a new request already pending.
    select        = 4'b0010;
    ready[1]      = 1'b1;
    status[3:2]   = 2'b00;
    request_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("bp_valid", {31'd0, response_valid}, 32'd1);
      check("bp_status", {30'd0, resp_status}, 32'd0);
      check("bp_data", read_data, 32'hCAFEF00D);
      check("bp_req_ready", {31'd0, request_ready}, 32'd0);
      tick();
    end
    response_ready = 1'b1;
    check("bp_req_ready_hs", {31'd0, request_ready}, 32'd0);
    tick();
    response_ready = 1'b0;
    check("bp_valid_drop", {31'd0, response_valid}, 32'd0);
    check("bp_req_ready_after", {31'd0, request_ready}, 32'd1);
    tick();
    request_valid = 1'b0;
    check("bp_next_active", {31'd0, access_active}, 32'd1);
    tick();
    check("bp_next_status", {30'd0, resp_status}, 32'd0);
    check("bp_next_data", read_data, 32'hFFFF0000);
    response_ready = 1'b1;
    ready          = 4'b0000;
    tick();
    response_ready = 1'b0;

    // Reset during WAIT.
    select        = 4'b0100;
    request_valid = 1'b1;
    tick();
    request_valid = 1'b0;
    check("rstw_pre_active", {31'd0, access_active}, 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_wait");
    #1;
    rst = 1'b0;
    tick();

    // Reset during RESP with a live read result.
    ready[2]      = 1'b1;
    request_valid = 1'b1;
    tick();
    request_valid = 1'b0;
    tick();
    check("rstr_pre_data", read_data, 32'hDEADBEEF);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_resp");
    #1;
    rst = 1'b0;
    ready = 4'b0000;
    tick();

    // Normal access after reset.
    select         = 4'b0001;
    status[1:0]    = 2'b00;
    data[0 +: 32]  = 32'h00005A5A;
    ready[0]       = 1'b1;
    request_valid  = 1'b1;
    tick();
    request_valid  = 1'b0;
    check("post_active", {31'd0, access_active}, 32'd1);
    tick();
    check("post_valid", {31'd0, response_valid}, 32'd1);
    check("post_status", {30'd0, resp_status}, 32'd0);
    check("post_data", read_data, 32'h00005A5A);
    response_ready = 1'b1;
    tick();
    response_ready = 1'b0;
    check("post_idle", {31'd0, request_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rggen_response_stage.md
Name: rggen_response_stage

Overview:
- Sequential stage directly downstream of the one-hot read-data mux in the register block.
- Accepts one host access at a time and drives an access strobe to the register entries.
- Waits for the selected entry's ready and AND-OR muxes that entry's data and status, using the existing rggen_mux primitive as a submodule.
- Registers the result and holds it on a valid/ready response handshake toward the host bus bridge. Generates decode-error and timeout responses itself.

Parameters:
- DATA_WIDTH, 32, read data width per entry.
- ENTRIES, 2, number of register entries (at least 1).
- TIMEOUT, 0, cycles to wait for entry ready before SLVERR; 0 disables the timeout.

Ports:
- i_clk  input  1  clock; all state on rising edge.
- i_rst  input  1  asynchronous active-high reset.
- i_request_valid  input  1  host access pending; held with i_request_write until accepted.
- o_request_ready  output  1  request accepted this cycle when both valid and ready are high.
- i_request_write  input  1  1 = write access, 0 = read access.
- i_select  input  ENTRIES  address-hit vector; upstream holds it stable from accept until response.
- o_access_active  output  1  access strobe to the entries; high only in WAIT.
- i_ready  input  ENTRIES  per-entry access-complete flags.
- i_status  input  2*ENTRIES  per-entry status; entry i uses bits [2i+1:2i].
- i_data  input  DATA_WIDTH*ENTRIES  per-entry read data, flattened.
- o_response_valid  output  1  response available.
- i_response_ready  input  1  host takes the response.
- o_status  output  2  response status: 00 OKAY, 10 SLVERR, 11 DECERR.
- o_read_data  output  DATA_WIDTH  registered read data.

Behaviour:
- Reset state:
  - FSM in IDLE; o_response_valid=0; o_status=00; o_read_data=0; o_access_active=0; timeout counter=0.
  - o_request_ready=1 immediately after reset (combinational from IDLE).
- FSM states: IDLE, WAIT, RESP.
  - o_request_ready = (state==IDLE).
  - o_access_active = (state==WAIT).
- IDLE, with i_request_valid=1:
  - i_select has exactly one bit set -> WAIT; timeout counter cleared.
  - i_select is zero or multi-hot -> RESP with o_status=11 and o_read_data=0. o_response_valid rises on the next cycle (1-cycle latency).
- WAIT:
  - hit = |(i_select & i_ready).
  - On hit: capture the muxed status (OR of the selected slice) and the muxed data; go to RESP. o_response_valid is high in the cycle after the hit.
  - Data capture: for writes o_read_data is captured as 0; for reads it is the muxed i_data.
  - An entry's ready is ignored unless that entry is selected.
- Timeout (TIMEOUT>0):
  - The counter increments every WAIT cycle without a hit.
  - When the counter reaches TIMEOUT-1 with no hit -> RESP with status 10 and data 0.
  - A hit in that same cycle wins over the timeout.
  - TIMEOUT=0: WAIT holds indefinitely.
  - Counter width is the minimum needed to count to TIMEOUT, with 1 bit minimum.
- RESP:
  - o_response_valid=1; o_status and o_read_data are held stable while i_response_ready=0.
  - On i_response_ready=1: go to IDLE, deassert valid.
  - No new request is accepted in the same cycle as the response handshake; the earliest next accept is the following cycle.
- Reset asserted mid-operation:
  - All state returns immediately and asynchronously to reset values.
  - Any in-flight response is discarded.
  - o_access_active drops without waiting for the clock.
- Minimum access:
  - Accept at cycle N; WAIT at N+1.
  - Entry ready at N+1 -> o_response_valid at N+2.

Test Plan:
- ENTRIES=4, read, select=0100, i_ready[2] high 3 cycles after accept, data[2]=0xDEADBEEF, status 00 -> o_access_active high 3 cycles; o_response_valid 1 cycle later with data 0xDEADBEEF, status 00.
- Write, select=0001, entry 0 status=10, ready 1 cycle after accept -> response status 10, o_read_data=0.
- select=0000, and separately select=0110 -> no cycles in WAIT, o_access_active never high; response 1 cycle after accept with status 11, data 0.
- TIMEOUT=8, select=1000, i_ready never high -> exactly 8 WAIT cycles, then status 10, data 0. Repeat with ready arriving on the 8th WAIT cycle -> status 00 with real data.
- Back-pressure: i_response_ready low for 4 cycles -> valid, status and data stable for all 4 cycles. o_request_ready stays low until the cycle after the handshake, even with i_request_valid held high.
- Assert i_rst during WAIT and again during RESP -> all outputs return to reset values before the next clock edge. Next request after reset completes normally.
